// File: rtl/fetch_pkg.sv
// fetch_pkg: shared constants, queue entry type and state enum for the fetch unit.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fetch_pkg;

   localparam int unsigned       ADDR_W           = 32;
   localparam int unsigned       INS_W            = 32;
   localparam logic [ADDR_W-1:0] PC_STEP          = 32'd4;
   localparam logic [ADDR_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

   typedef enum logic {
      RUN  = 1'b0,
      HALT = 1'b1
   } fetch_state_e;

   // One queue slot: fetched word tagged with the PC it was read from.
   typedef struct packed {
      logic [ADDR_W-1:0] pc;
      logic [INS_W-1:0]  ins;
   } fetch_entry_t;

   function automatic logic [ADDR_W-1:0] align_pc(input logic [ADDR_W-1:0] pc);
      return {pc[ADDR_W-1:2], 2'b00};
   endfunction

   function automatic logic pc_misaligned(input logic [ADDR_W-1:0] pc);
      return (pc[1:0] != 2'b00);
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: DEPTH-entry register FIFO with synchronous flush and occupancy count.
// Latency: push visible at head one cycle later; head is a registered array read.
// Backpressure: none internally; caller must never push when full or pop when empty.
//
// Ports: clk, rst_n (sync, active-low), flush (empties, overrides push/pop),
//        push_vld/push_dat (write), pop_rdy (consume head), head_vld/head_dat, count.
module fetch_fifo #(
   parameter int unsigned DEPTH = 2,
   parameter int unsigned W     = 64
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   flush,
   input  logic                   push_vld,
   input  logic [W-1:0]           push_dat,
   input  logic                   pop_rdy,
   output logic                   head_vld,
   output logic [W-1:0]           head_dat,
   output logic [$clog2(DEPTH):0] count
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [W-1:0]     mem_q [DEPTH];
   logic [W-1:0]     mem_d [DEPTH];
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_pop;

   assign head_vld = (count_q != '0);
   assign head_dat = mem_q[rd_ptr_q];
   assign count    = count_q;
   assign do_pop   = pop_rdy && head_vld;

   always_comb begin
      mem_d    = mem_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (flush) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push_vld) begin
            mem_d[wr_ptr_q] = push_dat;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
         end
         if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end
         // Push and pop together leave the count unchanged.
         count_d = count_q + CNT_W'(push_vld) - CNT_W'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: contents are only observed through count_q.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: owns the PC, issues in-order imem reads, queues words for decode.
// Latency: imem response to ins_valid is 1 cycle (registered queue).
// Backpressure: ins_ready stalls the queue; credits (queue + in-flight <= DEPTH) stop requests.
//
// Ports: clk, rst_n (sync, active-low); redirect_valid/redirect_target;
//        imem_req_valid/imem_req_ready/imem_req_addr; imem_rsp_valid/imem_rsp_data;
//        ins_valid/ins_ready/ins/ins_pc; fetch_fault.
// Build option FETCH_FAULT_EN: misaligned redirect halts fetch and raises fetch_fault;
// otherwise the target is word-aligned on load and fetch_fault stays 0.
module instr_fetch_unit
   import fetch_pkg::*;
#(
   parameter int unsigned       DEPTH    = 2,
   parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_target,
   output logic              imem_req_valid,
   input  logic              imem_req_ready,
   output logic [ADDR_W-1:0] imem_req_addr,
   input  logic              imem_rsp_valid,
   input  logic [INS_W-1:0]  imem_rsp_data,
   output logic              ins_valid,
   input  logic              ins_ready,
   output logic [INS_W-1:0]  ins,
   output logic [ADDR_W-1:0] ins_pc,
   output logic              fetch_fault
);

   localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

   fetch_state_e      state_q, state_d;
   logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
   logic [CNT_W-1:0]  outst_q, outst_d;
   logic [CNT_W-1:0]  drop_q, drop_d;
   logic              fault_q, fault_d;

   logic [CNT_W-1:0]  q_count;
   logic [CNT_W-1:0]  shd_count;
   logic [CNT_W:0]    credit_used;
   logic              req_acc;
   logic              rsp_take;
   logic              rsp_live;
   logic              q_head_vld;
   logic              shd_head_vld;
   logic [ADDR_W-1:0] shd_head_pc;
   fetch_entry_t      q_push_dat;
   fetch_entry_t      q_head_dat;
   logic              unused_shd;

   // Every word in flight or buffered holds a slot, so a response always fits.
   assign credit_used    = {1'b0, q_count} + {1'b0, outst_q};
   assign imem_req_valid = rst_n && (state_q == RUN) && (credit_used < (CNT_W+1)'(DEPTH));
   assign imem_req_addr  = fetch_pc_q;
   assign req_acc        = imem_req_valid && imem_req_ready;

   // Responses with nothing outstanding (e.g. straggling across a reset) are ignored.
   assign rsp_take = imem_rsp_valid && (outst_q != '0);
   // Non-stale response: its PC sits at the shadow head.
   assign rsp_live = rsp_take && (drop_q == '0) && shd_head_vld;

   assign q_push_dat  = '{pc: shd_head_pc, ins: imem_rsp_data};
   assign ins_valid   = rst_n && q_head_vld;
   assign ins         = q_head_dat.ins;
   assign ins_pc      = q_head_dat.pc;
   assign fetch_fault = rst_n && fault_q;
   assign unused_shd  = ^shd_count;

   fetch_fifo #(.DEPTH(DEPTH), .W($bits(fetch_entry_t))) u_ins_q (
      .clk      (clk),
      .rst_n    (rst_n),
      .flush    (redirect_valid),
      .push_vld (rsp_live && !redirect_valid),
      .push_dat (q_push_dat),
      .pop_rdy  (ins_valid && ins_ready),
      .head_vld (q_head_vld),
      .head_dat (q_head_dat),
      .count    (q_count)
   );

   // PCs of live requests, in issue order, waiting for their data.
   fetch_fifo #(.DEPTH(DEPTH), .W(ADDR_W)) u_pc_shadow (
      .clk      (clk),
      .rst_n    (rst_n),
      .flush    (redirect_valid),
      .push_vld (req_acc && !redirect_valid),
      .push_dat (fetch_pc_q),
      .pop_rdy  (rsp_live),
      .head_vld (shd_head_vld),
      .head_dat (shd_head_pc),
      .count    (shd_count)
   );

   always_comb begin
      state_d    = state_q;
      fault_d    = fault_q;
      fetch_pc_d = fetch_pc_q;
      drop_d     = drop_q;
      outst_d    = outst_q + CNT_W'(req_acc) - CNT_W'(rsp_take);
      if (rsp_take && (drop_q != '0)) begin
         drop_d = drop_q - CNT_W'(1);
      end
      if (req_acc) begin
         fetch_pc_d = fetch_pc_q + PC_STEP;
      end
      if (redirect_valid) begin
         // Everything still in flight after this edge, including a request
         // accepted right now, belongs to the old path.
         drop_d = outst_d;
`ifdef FETCH_FAULT_EN
         fetch_pc_d = redirect_target;
         if (pc_misaligned(redirect_target)) begin
            state_d = HALT;
            fault_d = 1'b1;
         end else begin
            state_d = RUN;
            fault_d = 1'b0;
         end
`else
         fetch_pc_d = align_pc(redirect_target);
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= RUN;
         fault_q    <= 1'b0;
         fetch_pc_q <= RESET_PC;
         outst_q    <= '0;
         drop_q     <= '0;
      end else begin
         state_q    <= state_d;
         fault_q    <= fault_d;
         fetch_pc_q <= fetch_pc_d;
         outst_q    <= outst_d;
         drop_q     <= drop_d;
      end
   end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: randomized bench with an in-order memory model and a
// program-order model of the fetch stream.
// Latency: n/a. Backpressure: consumer and memory readiness randomized per phase.
`timescale 1ns/1ps
module tb_instr_fetch_unit;

   localparam int DEPTH = 2;
   localparam logic [31:0] RST_PC = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        redirect_valid;
   logic [31:0] redirect_target;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        ins_valid;
   logic        ins_ready;
   logic [31:0] ins;
   logic [31:0] ins_pc;
   logic        fetch_fault;

   always #5 clk = ~clk;

   instr_fetch_unit #(.DEPTH(DEPTH), .RESET_PC(RST_PC)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .redirect_valid  (redirect_valid),
      .redirect_target (redirect_target),
      .imem_req_valid  (imem_req_valid),
      .imem_req_ready  (imem_req_ready),
      .imem_req_addr   (imem_req_addr),
      .imem_rsp_valid  (imem_rsp_valid),
      .imem_rsp_data   (imem_rsp_data),
      .ins_valid       (ins_valid),
      .ins_ready       (ins_ready),
      .ins             (ins),
      .ins_pc          (ins_pc),
      .fetch_fault     (fetch_fault)
   );

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   // stimulus knobs
   int          rdy_pct = 100;
   int          ird_pct = 100;
   int          lat     = 1;
   bit          rst_now = 1'b0;
   bit          redir_now = 1'b0;
   logic [31:0] redir_tgt = 32'h0;
   bit          redir_on_collision = 1'b0;
   bit          collided = 1'b0;

   // memory model: accepted requests in order, each with its due cycle
   typedef struct {
      int          due;
      logic [31:0] addr;
   } mreq_t;
   mreq_t mq[$];

   // program-order model
   logic [31:0] exp_req_pc;
   logic [31:0] exp_pc;
   bit          fault_m;
   logic [31:0] dlv[$];
   int          acc_cnt;
   logic        last_ins_valid;
   logic        last_fault;

   function automatic logic [31:0] memword(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'hDEAD_BEEF;
   endfunction

   function automatic logic [31:0] eff_target(input logic [31:0] t);
`ifdef FETCH_FAULT_EN
      return t;
`else
      return {t[31:2], 2'b00};
`endif
   endfunction

   function automatic bit target_faults(input logic [31:0] t);
`ifdef FETCH_FAULT_EN
      return (t[1:0] != 2'b00);
`else
      return (t[1:0] == 2'b11) && 1'b0;
`endif
   endfunction

   function automatic logic [31:0] dlv_at(input int i);
      if (dlv.size() > i) return dlv[i];
      return 32'hFFFF_FFFF;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic check_cycle();
      mreq_t r;
      last_ins_valid = ins_valid;
      last_fault     = fetch_fault;
      if (!rst_n) begin
         chk("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
         chk("rst_ins_valid", {31'b0, ins_valid}, 32'd0);
         chk("rst_fetch_fault", {31'b0, fetch_fault}, 32'd0);
         mq.delete();
         exp_req_pc = RST_PC;
         exp_pc     = RST_PC;
         fault_m    = 1'b0;
      end else begin
         chk("fetch_fault", {31'b0, fetch_fault}, {31'b0, fault_m});
         if (fault_m) chk("halt_no_req", {31'b0, imem_req_valid}, 32'd0);
         if (imem_req_valid) chk("credit_limit", {31'b0, (mq.size() < DEPTH)}, 32'd1);
         if (imem_req_valid && imem_req_ready) begin
            chk("req_addr", imem_req_addr, exp_req_pc);
            r.due  = cyc + lat;
            r.addr = imem_req_addr;
            mq.push_back(r);
            exp_req_pc = exp_req_pc + 32'd4;
            acc_cnt++;
         end
         if (imem_rsp_valid) void'(mq.pop_front());
         if (ins_valid) begin
            chk("ins_pc", ins_pc, exp_pc);
            chk("ins_word", ins, memword(ins_pc));
            if (ins_ready) begin
               dlv.push_back(ins_pc);
               exp_pc = exp_pc + 32'd4;
            end
         end
         if (redirect_valid) begin
            exp_req_pc = eff_target(redirect_target);
            exp_pc     = eff_target(redirect_target);
            fault_m    = target_faults(redirect_target);
         end
      end
   endtask

   task automatic step();
      @(negedge clk);
      rst_n           = !rst_now;
      imem_req_ready  = (int'($urandom_range(99)) < rdy_pct);
      ins_ready       = (int'($urandom_range(99)) < ird_pct);
      redirect_valid  = redir_now;
      redirect_target = redir_tgt;
      imem_rsp_valid  = 1'b0;
      imem_rsp_data   = $urandom;
      if (!rst_now && mq.size() > 0 && mq[0].due <= cyc) begin
         imem_rsp_valid = 1'b1;
         imem_rsp_data  = memword(mq[0].addr);
      end
      #1;
      if (redir_on_collision && rst_n && imem_req_valid && imem_req_ready && imem_rsp_valid) begin
         redirect_valid     = 1'b1;
         redirect_target    = redir_tgt;
         redir_on_collision = 1'b0;
         collided           = 1'b1;
      end
      #1;
      check_cycle();
      @(posedge clk);
      cyc++;
   endtask

   task automatic do_reset(input int n);
      rst_now = 1'b1;
      repeat (n) step();
      rst_now = 1'b0;
      dlv.delete();
      acc_cnt = 0;
   endtask

   task automatic redirect_once(input logic [31:0] t);
      redir_now = 1'b1;
      redir_tgt = t;
      step();
      redir_now = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; redirect_valid = 1'b0; redirect_target = '0;
      imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0; ins_ready = 1'b0;
      exp_req_pc = RST_PC; exp_pc = RST_PC; fault_m = 1'b0; acc_cnt = 0;
      last_ins_valid = 1'b0; last_fault = 1'b0;

      // 1: streaming from reset
      rdy_pct = 100; ird_pct = 100; lat = 1;
      do_reset(3);
      repeat (30) step();
      chk("s1_first_pc", dlv_at(0), 32'h0);
      chk("s1_second_pc", dlv_at(1), 32'h4);
      chk("s1_rate", {31'b0, (dlv.size() >= 15)}, 32'd1);

      // 2: consumer stalled, credits cap requests at DEPTH
      ird_pct = 0;
      do_reset(2);
      repeat (10) step();
      chk("s2_req_count", acc_cnt, 32'd2);
      chk("s2_held_valid", {31'b0, last_ins_valid}, 32'd1);
      ird_pct = 100;
      repeat (20) step();
      chk("s2_resume_first", dlv_at(0), 32'h0);
      chk("s2_resume_third", dlv_at(2), 32'h8);

      // 3: redirect with two slow requests in flight
      lat = 3; ird_pct = 0;
      do_reset(2);
      for (int i = 0; i < 20; i++) begin
         if (mq.size() == 2) break;
         step();
      end
      chk("s3_two_outstanding", mq.size(), 32'd2);
      redirect_once(32'h40);
      dlv.delete();
      ird_pct = 100;
      repeat (20) step();
      chk("s3_first_pc", dlv_at(0), 32'h40);
      chk("s3_second_pc", dlv_at(1), 32'h44);

      // 4: redirect lands on a response and an accept in the same cycle
      lat = 1; ird_pct = 100;
      do_reset(2);
      collided = 1'b0; redir_tgt = 32'h100; redir_on_collision = 1'b1;
      repeat (26) step();
      redir_on_collision = 1'b0;
      chk("s4_collision_seen", {31'b0, collided}, 32'd1);
      chk("s4_first_pc", dlv_at(0), 32'h100);
      chk("s4_second_pc", dlv_at(1), 32'h104);

      // 5: misaligned redirect then aligned recovery
      lat = 2;
      do_reset(2);
      repeat (10) step();
      redirect_once(32'h42);
      dlv.delete(); acc_cnt = 0;
      repeat (12) step();
`ifdef FETCH_FAULT_EN
      chk("s5_fault_set", {31'b0, last_fault}, 32'd1);
      chk("s5_no_delivery", dlv.size(), 32'd0);
      chk("s5_no_requests", acc_cnt, 32'd0);
`else
      chk("s5_fault_tied", {31'b0, last_fault}, 32'd0);
      chk("s5_aligned_first", dlv_at(0), 32'h40);
`endif
      redirect_once(32'h80);
      dlv.delete();
      repeat (12) step();
      chk("s5_recover_pc", dlv_at(0), 32'h80);
      chk("s5_fault_clear", {31'b0, last_fault}, 32'd0);

      // 6: reset with a full queue
      lat = 1; ird_pct = 0;
      do_reset(2);
      repeat (10) step();
      chk("s6_queue_full", {31'b0, last_ins_valid}, 32'd1);
      rst_now = 1'b1; step(); rst_now = 1'b0;
      ird_pct = 100;
      dlv.delete();
      step();
      chk("s6_empty_after_rst", {31'b0, last_ins_valid}, 32'd0);
      repeat (20) step();
      chk("s6_refetch_pc", dlv_at(0), RST_PC);

      // 7: randomized backpressure, latency and redirects
      do_reset(2);
      for (int ph = 0; ph < 6; ph++) begin
         lat     = int'($urandom_range(1, 4));
         rdy_pct = int'($urandom_range(40, 100));
         ird_pct = int'($urandom_range(40, 100));
         repeat (100) begin
            redir_now = (int'($urandom_range(99)) < 4);
            redir_tgt = $urandom & 32'h0000_0FFF;
            if ($urandom_range(3) != 0) redir_tgt[1:0] = 2'b00;
            step();
         end
      end
      redir_now = 1'b0;
      rdy_pct = 100; ird_pct = 100;
      chk("s7_progress", {31'b0, (dlv.size() >= 30)}, 32'd1);

      // 8: PC wraps past the top of the address space
      lat = 1;
      redirect_once(32'hFFFF_FFF8);
      dlv.delete();
      repeat (15) step();
      chk("s8_wrap0", dlv_at(0), 32'hFFFF_FFF8);
      chk("s8_wrap1", dlv_at(1), 32'hFFFF_FFFC);
      chk("s8_wrap2", dlv_at(2), 32'h0000_0000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
